// File: rtl/ula_pkg.sv
// Shared types for the ula_arb ALU sequencer: opcode encoding, FSM states and an
// opcode legality helper used when the ULA_ARB_ERR_EN build option is enabled.
package ula_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        EQ  = 3'b101
    } op_e;

    localparam logic [2:0] OP_LAST = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/ula_rr_arb.sv
// Combinational round-robin picker: scans i_req starting at i_last_grant+1,
// wrapping modulo NREQ; the first set bit wins (one-hot plus encoded index).
module ula_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last_grant,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    // Rotated priority scan; once a candidate hits, all later candidates are masked
    always_comb begin
        logic w_found;
        logic w_hit;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                w_hit    = !w_found && i_req[j] && (j == ((int'(i_last_grant) + k) % NREQ));
                o_gnt[j] = o_gnt[j] | w_hit;
                o_idx    = w_hit ? IDW'(j) : o_idx;
                w_found  = w_found | w_hit;
            end
        end
    end

endmodule

// File: rtl/ula_arb.sv
// Round-robin sequencer sharing one external combinational ALU between NREQ requesters.
// Build option ULA_ARB_ERR_EN adds rsp_err and suppresses result capture for opcodes above OP_LAST.
module ula_arb
    import ula_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 4,
    parameter int OPW  = 3,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [OPW-1:0]    alu_op,
    input  logic [W-1:0]      alu_r,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_zero,
    output logic              busy
`ifdef ULA_ARB_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    state_e          r_state;
    state_e          w_next;
    logic [IDW-1:0]  r_last;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [OPW-1:0]  r_alu_op;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_rsp_r;
    logic            r_rsp_zero;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_accept;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [OPW-1:0]  w_sel_op;

    ula_rr_arb #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_rr (
        .i_req       (req_valid),
        .i_last_grant(r_last),
        .o_gnt       (w_gnt),
        .o_idx       (w_idx)
    );

    // Grant is only offered from IDLE and is forced low while reset is asserted
    assign req_ready = (r_state == IDLE && rst_n) ? w_gnt : '0;
    assign w_accept  = |(req_valid & req_ready);

    // One-hot payload mux selecting the winner's operands
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_a  = w_sel_a  | (req_a[i*W +: W]      & {W{w_gnt[i]}});
            w_sel_b  = w_sel_b  | (req_b[i*W +: W]      & {W{w_gnt[i]}});
            w_sel_op = w_sel_op | (req_op[i*OPW +: OPW] & {OPW{w_gnt[i]}});
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = EXEC;
                end else begin
                    w_next = IDLE;
                end
            end
            EXEC: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef ULA_ARB_ERR_EN
    logic r_rsp_err;
    assign rsp_err = r_rsp_err;
`endif

    // State, operand latch on accept, and result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= IDW'(NREQ - 1);
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_id       <= '0;
            r_rsp_r    <= '0;
            r_rsp_zero <= 1'b0;
`ifdef ULA_ARB_ERR_EN
            r_rsp_err  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
                r_id     <= w_idx;
                r_last   <= w_idx;
            end else if (r_state == EXEC) begin
`ifdef ULA_ARB_ERR_EN
                if (op_is_legal(r_alu_op)) begin
                    r_rsp_r    <= alu_r;
                    r_rsp_zero <= alu_zero;
                    r_rsp_err  <= 1'b0;
                end else begin
                    r_rsp_r    <= '0;
                    r_rsp_zero <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
`else
                r_rsp_r    <= alu_r;
                r_rsp_zero <= alu_zero;
`endif
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_id    = r_id;
    assign rsp_r     = r_rsp_r;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ula_arb.sv
// Scoreboard bench for ula_arb: directed scenarios plus randomized traffic, checked
// against a transaction-level model; an ALU stand-in drives alu_r/alu_zero.
module tb_ula_arb;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int OPW  = 3;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a = '0;
    logic [NREQ*W-1:0]   req_b = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [OPW-1:0]      alu_op;
    logic [W-1:0]        alu_r;
    logic                alu_zero;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_r;
    logic                rsp_zero;
    logic                busy;
`ifdef ULA_ARB_ERR_EN
    logic                rsp_err;
`endif

    ula_arb #(.NREQ(NREQ), .W(W), .OPW(OPW), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_r    (alu_r),
        .alu_zero (alu_zero),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_r    (rsp_r),
        .rsp_zero (rsp_zero),
        .busy     (busy)
`ifdef ULA_ARB_ERR_EN
        ,
        .rsp_err  (rsp_err)
`endif
    );

    // Stand-in for the external ALU
    always_comb begin
        case (alu_op)
            3'd0:    alu_r = alu_a + alu_b;
            3'd1:    alu_r = alu_a - alu_b;
            3'd2:    alu_r = alu_a & alu_b;
            3'd3:    alu_r = alu_a | alu_b;
            3'd4:    alu_r = alu_a ^ alu_b;
            3'd5:    alu_r = (alu_a == alu_b) ? 4'd1 : 4'd0;
            default: alu_r = 4'd0;
        endcase
        alu_zero = (alu_r == 4'd0);
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int r;
        int zero;
        int err;
        int cyc;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    bit              model_busy = 1'b0;
    bit              seen = 1'b0;
    int              m_last = NREQ - 1;
    logic [NREQ-1:0] acc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Next winner: first valid requester after the previous grant, wrapping around
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (bit_of(v, (last + k) % NREQ)) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic exp_t ref_op(input int id, input int a, input int b, input int op);
        exp_t e;
        int   m;
        m = 1 << W;
        e.id = id; e.err = 0; e.cyc = cyc;
        case (op)
            0:       e.r = (a + b) % m;
            1:       e.r = (a - b + m) % m;
            2:       e.r = a & b;
            3:       e.r = a | b;
            4:       e.r = a ^ b;
            5:       e.r = (a == b) ? 1 : 0;
            default: e.r = 0;
        endcase
        e.zero = (e.r == 0) ? 1 : 0;
`ifdef ULA_ARB_ERR_EN
        if (op > 5) begin
            e.r = 0; e.zero = 0; e.err = 1;
        end
`endif
        return e;
    endfunction

    function automatic int field(input logic [NREQ*W-1:0] v, input int i, input int w);
        logic [NREQ*W-1:0] t;
        t = v >> (i * w);
        return int'(t) & ((1 << w) - 1);
    endfunction

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_a     = (req_a & ~((NREQ*W)'(15) << (i*W))) | ((NREQ*W)'(a & 15) << (i*W));
        req_b     = (req_b & ~((NREQ*W)'(15) << (i*W))) | ((NREQ*W)'(b & 15) << (i*W));
        req_op    = (req_op & ~((NREQ*OPW)'(7) << (i*OPW))) | ((NREQ*OPW)'(op & 7) << (i*OPW));
        req_valid = req_valid | (NREQ'(1) << i);
    endtask

    task automatic drop_req(input int i);
        req_valid = req_valid & ~(NREQ'(1) << i);
    endtask

    // One cycle: check busy and grant against the model, record accepts, advance to next negedge
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        int win;
        #1;
        chk("busy", 32'(busy), 32'(model_busy));
        exp_rdy = '0;
        acc     = '0;
        win     = -1;
        if (!model_busy) win = rr_pick(req_valid, m_last);
        if (win >= 0) exp_rdy = NREQ'(1) << win;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (win >= 0) begin
            sb.push_back(ref_op(win, field(req_a, win, W), field(req_b, win, W),
                                field(NREQ*W'(0) | (NREQ*W)'(req_op), win, OPW)));
            m_last     = win;
            model_busy = 1'b1;
            acc        = exp_rdy;
        end
        @(negedge clk);
    endtask

    task automatic run_one(input int i, input int a, input int b, input int op);
        int n;
        set_req(i, a, b, op);
        n = 0;
        do begin
            step();
            n++;
        end while (!bit_of(acc, i) && n < 10);
        chk("grant_wait", 32'(bit_of(acc, i)), 32'd1);
        drop_req(i);
        repeat (4) step();
    endtask

    // Response monitor: compares the presented response with the queue head every valid cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        chk("latency", 32'(cyc - e.cyc), 32'd2);
                        seen = 1'b1;
                    end
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_r", 32'(rsp_r), 32'(e.r));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
`ifdef ULA_ARB_ERR_EN
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        seen       = 1'b0;
                        model_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        // Reset: outputs low even with a valid request pending
        set_req(0, 3, 5, 0);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_r", 32'(rsp_r), 32'd0);
        drop_req(0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, wrap-around add/sub, illegal opcode
        run_one(0, 3, 5, 0);
        run_one(0, 15, 1, 0);
        run_one(1, 0, 1, 1);
        run_one(0, 9, 3, 6);
        run_one(1, 12, 10, 2);

        // Contention: grants must alternate with both requesters continuously valid
        set_req(0, 5, 5, 1);
        set_req(1, 7, 7, 5);
        repeat (12) step();

        // Backpressure while both stay valid
        rsp_ready = 1'b0;
        repeat (8) step();
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (4) step();

        // Reset during EXEC: transaction discarded, requester 0 wins afterwards
        run_one(0, 1, 1, 0);
        set_req(0, 2, 2, 0);
        step();
        chk("exec_accept", 32'(acc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        sb.delete();
        seen       = 1'b0;
        model_busy = 1'b0;
        m_last     = NREQ - 1;
        req_valid  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        set_req(0, 4, 4, 4);
        set_req(1, 6, 6, 3);
        step();
        chk("post_rst_winner", 32'(acc), 32'd1);
        drop_req(0);
        drop_req(1);
        repeat (4) step();

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bit_of(req_valid, i)) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                int'($urandom_range(0, 7)));
                end else if ($urandom_range(0, 15) == 0) begin
                    drop_req(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (bit_of(acc, i)) drop_req(i);
            end
        end

        // Drain
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (model_busy && n < 20) begin
            step();
            n++;
        end
        chk("drain_busy", 32'(model_busy), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_arb.md
Name: ula_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational 4-bit ALU (ops 000–101) between NREQ requesters.
- Each requester offers an operation over a valid/ready handshake. The block latches the winner's operands, drives them onto the shared ALU, captures result and zero flag, and returns them tagged with the requester index.
- Sits between the requesting control units and the single ALU instance in the datapath.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 4, operand/result width; must match the ALU.
- OPW, 3, opcode width.
- IDW, 2, width of the requester tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*W  packed operand A, slice i belongs to requester i.
- req_b  in  NREQ*W  packed operand B.
- req_op  in  NREQ*OPW  packed opcode.
- alu_a  out  W  operand A to the shared ALU.
- alu_b  out  W  operand B to the shared ALU.
- alu_op  out  OPW  opcode to the shared ALU.
- alu_r  in  W  ALU result (combinational from alu_*).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_r  out  W  captured result.
- rsp_zero  out  1  captured zero flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - last_grant is set to NREQ-1, so requester 0 wins the first arbitration.
  - A reset mid-transaction discards it; no response is ever produced for it.
- FSM, three states:
  - IDLE: grant is combinational. Scan req_valid starting at last_grant+1, wrapping modulo NREQ; the first set bit wins. req_ready[winner] = 1; all other bits are 0. req_ready is 0 in every other state. On accept (req_valid & req_ready): latch a, b, op and id into alu_a/alu_b/alu_op/rsp_id registers, set last_grant = winner, go to EXEC. If no valid, stay in IDLE and leave last_grant unchanged.
  - EXEC: one cycle with alu_* stable. At the end of the cycle, capture alu_r into rsp_r and alu_zero into rsp_zero, then go to RESP.
  - RESP: rsp_valid = 1. Hold rsp_id, rsp_r and rsp_zero stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE; rsp_valid drops next cycle.
- Timing:
  - Latency is 2 cycles from the accept edge to rsp_valid high.
  - Best-case throughput is one operation per 3 cycles.
  - No new request is accepted in the cycle the response completes; acceptance resumes in IDLE.
- alu_a, alu_b and alu_op hold their last values until the next accept; they are not cleared after a response.
- Requesters keep payload stable while valid. A valid that drops before ready is simply not granted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. Each requester waits at most NREQ-1 transactions.
- Opcodes 110 and 111 are passed through unchanged; the result is whatever the ALU returns (0, so rsp_zero = 1).

Optional Feature:
- Macro ULA_ARB_ERR_EN.
- When defined:
  - Extra output rsp_err (1 bit, reset 0), registered with the response.
  - For opcodes >= 110: EXEC does not capture alu_r; rsp_r = 0, rsp_zero = 0, rsp_err = 1.
  - For valid opcodes, rsp_err = 0.
- When undefined: no port, and behaviour is exactly as above.

Decomposition:
- Package ula_pkg holds:
  - typedef for the opcode enum (ADD=000, SUB=001, AND=010, OR=011, XOR=011+1, EQ=101).
  - constant OP_LAST = 3'b101.
  - FSM state enum {IDLE, EXEC, RESP}.
- Sub-module ula_rr_arb: pure combinational round-robin priority picker.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant and encoded index.
- The ALU itself stays outside this block.

Test Plan:
- Single request: requester 0 valid with a=4'h3, b=4'h5, op=000 → req_ready[0] same cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_r=4'h8, rsp_zero=0.
- Contention: both valid continuously, requester 0 op=001 a=5 b=5 and requester 1 op=101 a=7 b=7 → responses alternate id 0,1,0,1. Requester 0 returns r=0, zero=1; requester 1 returns r=1, zero=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable; req_ready stays 0 although both requesters are valid.
- Wrap-around: a=4'hF, b=4'h1, op=000 → r=4'h0, zero=1. a=0, b=1, op=001 → r=4'hF, zero=0.
- Reset in EXEC: assert rst_n=0 mid-EXEC → outputs 0 immediately, no response after release, requester 0 wins the next arbitration.
- Illegal opcode: op=110 → without the macro, r=0 and zero=1. With ULA_ARB_ERR_EN, rsp_err=1, r=0, zero=0.
